mmcm_drp_sequencer: RTL

//   Generalised DRP reconfiguration engine for one or more 7-series MMCME2/PLLE2 primitives.

---
 rtl/mmcm_drp_sequencer.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/mmcm_drp_sequencer.sv
// DRP read-modify-write sequencer for MMCME2/PLLE2 primitives: applies a stream of masked
// register writes to one channel while holding it in reset, then waits for LOCKED.
module mmcm_drp_sequencer #(
  parameter int NUM_CH       = 1,
  parameter int CH_W         = 1,
  parameter int DRDY_TIMEOUT = 64,
  parameter int LOCK_TIMEOUT = 65536
) (
  input  logic                 dclk,
  input  logic                 rst_n,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [CH_W-1:0]      cfg_ch,
  input  logic [6:0]           cfg_addr,
  input  logic [15:0]          cfg_data,
  input  logic [15:0]          cfg_mask,
  input  logic                 cfg_last,
  output logic [6:0]           daddr,
  output logic [15:0]          di,
  output logic                 dwe,
  output logic [NUM_CH-1:0]    den,
  input  logic [NUM_CH*16-1:0] do_bus,
  input  logic [NUM_CH-1:0]    drdy,
  output logic [NUM_CH-1:0]    rst_mmcm,
  input  logic [NUM_CH-1:0]    locked,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [1:0]           err_code,
  output logic [2:0]           dbg_state
);

  localparam int MAX_TO = (DRDY_TIMEOUT > LOCK_TIMEOUT) ? DRDY_TIMEOUT : LOCK_TIMEOUT;
  localparam int CNT_W  = $clog2(MAX_TO) + 1;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_RD        = 3'd2,
    S_RD_WAIT   = 3'd3,
    S_WR        = 3'd4,
    S_WR_WAIT   = 3'd5,
    S_HOLDOFF   = 3'd6,
    S_LOCK_WAIT = 3'd7
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CH_W-1:0]    r_ch;
  logic [6:0]         r_addr;
  logic [15:0]        r_data, r_mask, r_di;
  logic               r_last, r_busy, r_done, r_error;
  logic [1:0]         r_err_code;
  logic [NUM_CH-1:0]  r_rst;

  logic [NUM_CH-1:0]  w_ch_oh, w_cfg_oh;
  logic [15:0]        w_sel_do;
  logic               w_sel_drdy, w_sel_locked, w_accept, w_skip_rd, w_drdy_to, w_lock_to;

  always_comb begin
    w_ch_oh  = '0;
    w_cfg_oh = '0;
    w_sel_do = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      w_ch_oh[c]  = (r_ch == CH_W'(c));
      w_cfg_oh[c] = (cfg_ch == CH_W'(c));
      if (r_ch == CH_W'(c)) w_sel_do = do_bus[c*16 +: 16];
    end
  end

  assign w_sel_drdy   = |(drdy & w_ch_oh);
  assign w_sel_locked = |(locked & w_ch_oh);
  assign w_accept     = cfg_valid & cfg_ready;
  assign w_skip_rd    = (cfg_mask == 16'hFFFF);
  assign w_drdy_to    = (r_cnt == CNT_W'(DRDY_TIMEOUT - 1));
  assign w_lock_to    = (r_cnt == CNT_W'(LOCK_TIMEOUT - 1));

  // Handshake: an entry transfers on a dclk edge where cfg_valid and cfg_ready are both high;
  // cfg_ready depends only on state (and rst_n), never on cfg_valid.
  always_comb begin
    w_state_nxt = r_state;
    cfg_ready   = 1'b0;
    den         = '0;
    dwe         = 1'b0;
    case (r_state)
      S_IDLE, S_FETCH: begin
        cfg_ready = rst_n;
        if (w_accept) w_state_nxt = w_skip_rd ? S_WR : S_RD;
      end
      S_RD: begin
        den         = w_ch_oh;
        w_state_nxt = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (w_sel_drdy)     w_state_nxt = S_WR;
        else if (w_drdy_to) w_state_nxt = S_IDLE;
      end
      S_WR: begin
        den         = w_ch_oh;
        dwe         = 1'b1;
        w_state_nxt = S_WR_WAIT;
      end
      S_WR_WAIT: begin
        if (w_sel_drdy)     w_state_nxt = r_last ? S_HOLDOFF : S_FETCH;
        else if (w_drdy_to) w_state_nxt = S_IDLE;
      end
      S_HOLDOFF: begin
        if (r_cnt == CNT_W'(3)) w_state_nxt = S_LOCK_WAIT;
      end
      S_LOCK_WAIT: begin
        if (w_sel_locked || w_lock_to) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge dclk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_ch       <= '0;
      r_addr     <= '0;
      r_data     <= '0;
      r_mask     <= '0;
      r_di       <= '0;
      r_last     <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_err_code <= 2'd0;
      r_rst      <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= (w_state_nxt != r_state) ? '0 : r_cnt + 1'b1;
      r_done  <= 1'b0;
      r_error <= 1'b0;
      if (w_accept) begin
        r_addr <= cfg_addr;
        r_data <= cfg_data;
        r_mask <= cfg_mask;
        r_last <= cfg_last;
        if (w_skip_rd) r_di <= cfg_data;
        if (r_state == S_IDLE) begin
          r_ch       <= cfg_ch;
          r_err_code <= 2'd0;
          r_busy     <= 1'b1;
          r_rst      <= w_cfg_oh;
        end
      end
      case (r_state)
        S_RD_WAIT: begin
          if (w_sel_drdy) begin
            r_di <= (w_sel_do & ~r_mask) | (r_data & r_mask);
          end else if (w_drdy_to) begin
            r_error    <= 1'b1;
            r_err_code <= 2'd1;
            r_rst      <= '0;
            r_busy     <= 1'b0;
          end
        end
        S_WR_WAIT: begin
          if (w_sel_drdy) begin
            if (r_last) r_rst <= '0;
          end else if (w_drdy_to) begin
            r_error    <= 1'b1;
            r_err_code <= 2'd1;
            r_rst      <= '0;
            r_busy     <= 1'b0;
          end
        end
        S_LOCK_WAIT: begin
          if (w_sel_locked) begin
            r_done <= 1'b1;
            r_busy <= 1'b0;
          end else if (w_lock_to) begin
            r_error    <= 1'b1;
            r_err_code <= 2'd2;
            r_rst      <= '0;
            r_busy     <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign daddr     = r_addr;
  assign di        = r_di;
  assign rst_mmcm  = r_rst;
  assign busy      = r_busy;
  assign done      = r_done;
  assign error     = r_error;
  assign err_code  = r_err_code;
  assign dbg_state = r_state;

endmodule
